// File: rtl/id_ex_if.sv
// ID/EX stage bus: ID-side fields, WB write port, hold/squash controls
// and registered EX-side outputs.
interface id_ex_if #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [31:0]       id_rd1;
  logic [31:0]       id_rd2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_regwrite;
  logic [4:0]        wb_wa;
  logic [31:0]       wb_wd;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_a;
  logic [31:0]       ex_b;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              hazard_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_pc,
    output id_rs, id_rt, id_rd, id_rd1,
    output id_rd2, id_imm, id_ctrl,
    output wb_regwrite, wb_wa, wb_wd,
    input  ex_valid, ex_pc, ex_imm, ex_rs,
    input  ex_rt, ex_rd, ex_a, ex_b,
    input  ex_ctrl, hazard_stall, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_pc,
    input  id_rs, id_rt, id_rd, id_rd1,
    input  id_rd2, id_imm, id_ctrl,
    input  wb_regwrite, wb_wa, wb_wd,
    output ex_valid, ex_pc, ex_imm, ex_rs,
    output ex_rt, ex_rd, ex_a, ex_b,
    output ex_ctrl, hazard_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Define ID_BYPASS_EN to forward the same-cycle WB write into ex_a/ex_b.
module id_ex_stage #(
  parameter int CTRL_W      = 12,
  parameter int MEMREAD_BIT = 3,
  parameter int CNT_W       = 16
) (
  input logic   clk,
  input logic   rstn,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t              r;
  ex_t              ld;
  ex_t              nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             hz;
  logic [31:0]      op_a;
  logic [31:0]      op_b;

  assign hz = bus.id_valid & r.valid
            & r.ctrl[MEMREAD_BIT]
            & (r.rt != 5'd0)
            & ((r.rt == bus.id_rs) |
               (r.rt == bus.id_rt));

`ifdef ID_BYPASS_EN
  logic hit_a;
  logic hit_b;

  assign hit_a = bus.wb_regwrite
               & (bus.wb_wa != 5'd0)
               & (bus.wb_wa == bus.id_rs);
  assign hit_b = bus.wb_regwrite
               & (bus.wb_wa != 5'd0)
               & (bus.wb_wa == bus.id_rt);
  assign op_a = hit_a ? bus.wb_wd : bus.id_rd1;
  assign op_b = hit_b ? bus.wb_wd : bus.id_rd2;
`else
  logic unused_wb;

  assign unused_wb = ^{bus.wb_regwrite,
                       bus.wb_wa, bus.wb_wd};
  assign op_a = bus.id_rd1;
  assign op_b = bus.id_rd2;
`endif

  always_comb begin
    ld       = '0;
    ld.valid = bus.id_valid;
    ld.pc    = bus.id_pc;
    ld.imm   = bus.id_imm;
    ld.rs    = bus.id_rs;
    ld.rt    = bus.id_rt;
    ld.rd    = bus.id_rd;
    ld.a     = op_a;
    ld.b     = op_b;
    ld.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
  end

  // One action per edge: squash beats hold beats bubble beats load.
  always_comb begin
    nxt   = r;
    cnt_n = cnt;
    if (bus.flush) begin
      nxt = '0;
    end else if (bus.stall) begin
      nxt = r;
    end else if (hz) begin
      nxt       = ld;
      nxt.valid = 1'b0;
      nxt.ctrl  = '0;
      if (cnt != '1)
        cnt_n = cnt + 1'b1;
    end else begin
      nxt = ld;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r   <= '0;
      cnt <= '0;
    end else begin
      r   <= nxt;
      cnt <= cnt_n;
    end
  end

  assign bus.ex_valid     = r.valid;
  assign bus.ex_pc        = r.pc;
  assign bus.ex_imm       = r.imm;
  assign bus.ex_rs        = r.rs;
  assign bus.ex_rt        = r.rt;
  assign bus.ex_rd        = r.rd;
  assign bus.ex_a         = r.a;
  assign bus.ex_b         = r.b;
  assign bus.ex_ctrl      = r.ctrl;
  assign bus.hazard_stall = hz;
  assign bus.bubble_cnt   = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a cycle-level reference model;
// a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  id_ex_if #(.CTRL_W(12), .CNT_W(16)) bus ();
  id_ex_if #(.CTRL_W(12), .CNT_W(2))  bus2 ();

  assign bus2.stall       = bus.stall;
  assign bus2.flush       = bus.flush;
  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_pc       = bus.id_pc;
  assign bus2.id_rs       = bus.id_rs;
  assign bus2.id_rt       = bus.id_rt;
  assign bus2.id_rd       = bus.id_rd;
  assign bus2.id_rd1      = bus.id_rd1;
  assign bus2.id_rd2      = bus.id_rd2;
  assign bus2.id_imm      = bus.id_imm;
  assign bus2.id_ctrl     = bus.id_ctrl;
  assign bus2.wb_regwrite = bus.wb_regwrite;
  assign bus2.wb_wa       = bus.wb_wa;
  assign bus2.wb_wd       = bus.wb_wd;

  id_ex_stage #(
    .CTRL_W(12), .MEMREAD_BIT(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave)
  );

  id_ex_stage #(
    .CTRL_W(12), .MEMREAD_BIT(3), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t",
               tag, obs, exp, $time);
    end
  endtask

`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Architectural view of the EX latch
  bit          m_valid;
  logic [31:0] m_pc, m_imm, m_a, m_b;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [11:0] m_ctrl;
  int          m_cnt, m_cnt2;
  bit          m_data_ok;

  task automatic m_reset();
    m_valid = 0; m_pc = 0; m_imm = 0;
    m_a = 0; m_b = 0; m_rs = 0;
    m_rt = 0; m_rd = 0; m_ctrl = 0;
    m_cnt = 0; m_cnt2 = 0; m_data_ok = 1;
  endtask

  function automatic bit m_hz();
    if (!bus.id_valid || !m_valid) return 0;
    if (!m_ctrl[3] || m_rt == 0) return 0;
    return (m_rt == bus.id_rs) ||
           (m_rt == bus.id_rt);
  endfunction

  function automatic logic [31:0] fwd(
      input logic [4:0] ra,
      input logic [31:0] rf);
    if (BYP && bus.wb_regwrite &&
        bus.wb_wa != 0 && bus.wb_wa == ra)
      return bus.wb_wd;
    return rf;
  endfunction

  task automatic check_all(input string t);
    chk({t, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
    chk({t, ".ctrl"}, 32'(bus.ex_ctrl), 32'(m_ctrl));
    chk({t, ".cnt"}, 32'(bus.bubble_cnt), m_cnt);
    chk({t, ".cnt2"}, 32'(bus2.bubble_cnt), m_cnt2);
    chk({t, ".valid2"}, 32'(bus2.ex_valid), 32'(m_valid));
    if (m_data_ok) begin
      chk({t, ".pc"}, bus.ex_pc, m_pc);
      chk({t, ".imm"}, bus.ex_imm, m_imm);
      chk({t, ".a"}, bus.ex_a, m_a);
      chk({t, ".b"}, bus.ex_b, m_b);
      chk({t, ".rs"}, 32'(bus.ex_rs), 32'(m_rs));
      chk({t, ".rt"}, 32'(bus.ex_rt), 32'(m_rt));
      chk({t, ".rd"}, 32'(bus.ex_rd), 32'(m_rd));
    end
  endtask

  // Called just after a negedge with inputs driven
  task automatic step(input string t);
    bit hz;
    #1;
    hz = m_hz();
    chk({t, ".hz"}, 32'(bus.hazard_stall), 32'(hz));
    if (bus.flush) begin
      m_valid = 0; m_pc = 0; m_imm = 0;
      m_a = 0; m_b = 0; m_rs = 0;
      m_rt = 0; m_rd = 0; m_ctrl = 0;
      m_data_ok = 1;
    end else if (bus.stall) begin
    end else if (hz) begin
      m_valid = 0; m_ctrl = 0; m_data_ok = 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_valid = bus.id_valid;
      m_ctrl  = bus.id_valid ? bus.id_ctrl : 12'h0;
      m_pc  = bus.id_pc;  m_imm = bus.id_imm;
      m_rs  = bus.id_rs;  m_rt  = bus.id_rt;
      m_rd  = bus.id_rd;
      m_a = fwd(bus.id_rs, bus.id_rd1);
      m_b = fwd(bus.id_rt, bus.id_rd2);
      m_data_ok = 1;
    end
    @(posedge clk);
    #1;
    check_all(t);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_pc = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rd1 = 0; bus.id_rd2 = 0;
    bus.id_imm = 0; bus.id_ctrl = 0;
    bus.wb_regwrite = 0; bus.wb_wa = 0;
    bus.wb_wd = 0;
  endtask

  task automatic instr(input bit v,
                       input logic [31:0] pc,
                       input logic [4:0] rs, rt, rd,
                       input logic [31:0] d1, d2,
                       input logic [11:0] ctl);
    bus.id_valid = v; bus.id_pc = pc;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rd1 = d1; bus.id_rd2 = d2;
    bus.id_imm = pc ^ 32'h5a5a_0000;
    bus.id_ctrl = ctl;
  endtask

  task automatic async_reset(input string t);
    #2 rstn = 0;
    #1;
    m_reset();
    chk({t, ".hz"}, 32'(bus.hazard_stall), 0);
    check_all(t);
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    rstn = 0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    check_all("rst0");
    rstn = 1;

    instr(1, 32'h40, 1, 2, 3, 32'h11, 32'h22, 12'h005);
    step("pass");

    instr(1, 32'h44, 1, 8, 8, 32'h1, 32'h2, 12'h008);
    step("lw");
    instr(1, 32'h48, 8, 9, 10, 32'h3, 32'h4, 12'h001);
    step("lu_bub");
    step("lu_go");

    instr(1, 32'h4c, 4, 5, 6, 32'h7, 32'h8, 12'h0a3);
    step("pre_st");
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr(1, $urandom, 5'($urandom), 5'($urandom),
            5'($urandom), $urandom, $urandom,
            12'($urandom));
      step("stall");
    end
    bus.flush = 1;
    step("st_fl");
    idle();

    instr(1, 32'h50, 8, 8, 8, 32'h9, 32'ha, 12'h7ff);
    step("pre_rst");
    async_reset("rst_mid");

    idle();
    bus.wb_regwrite = 1; bus.wb_wa = 5;
    bus.wb_wd = 32'hdeadbeef;
    instr(1, 32'h60, 5, 6, 7, 0, 32'h66, 12'h001);
    step("byp");
    bus.wb_wa = 0;
    instr(1, 32'h64, 0, 0, 7, 0, 32'h66, 12'h001);
    step("byp0");
    idle();

    for (int i = 0; i < 5; i++) begin
      instr(1, 32'h100 + i, 1, 9, 9, i, i, 12'h008);
      step("sat_lw");
      instr(1, 32'h200 + i, 2, 9, 3, i, i, 12'h002);
      step("sat_use");
    end
    chk("sat_cnt2", 32'(bus2.bubble_cnt), 3);

    for (int i = 0; i < 3000; i++) begin
      bus.stall = ($urandom_range(0, 9) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      instr($urandom_range(0, 4) != 0, $urandom,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom), $urandom, $urandom,
            {11'($urandom), 1'b0} |
            ($urandom_range(0, 1) ? 12'h008 : 12'h0));
      bus.wb_regwrite = 1'($urandom);
      bus.wb_wa = 5'($urandom_range(0, 3));
      bus.wb_wd = $urandom;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
